// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: counter encodings and PC slicing helpers shared by the predictor
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;
    localparam logic [1:0] BHT_RESET = WNT;

    // Table index: word-aligned PC bits directly above the byte offset
    function automatic logic [63:0] pc_bidx(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Tag: every PC bit above the index field
    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// sat_counter: next-value logic for a saturating up/down counter with clear
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cnt_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    // Clear wins; increment stops at all-ones, decrement stops at zero
    always_comb
        cnt_o = clr_i ? '0 :
                (inc_i && cnt_i != '1) ? cnt_i + 1'b1 :
                (dec_i && cnt_i != '0) ? cnt_i - 1'b1 : cnt_i;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BHT + tagged BTB with same-cycle lookup, ID-stage update and statistics
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int GSHARE  = 0,
    parameter int GHR_W   = 4,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lk_valid_i,
    input  logic [XLEN-1:0]  lk_pc_i,
    output logic             pred_taken_o,
    output logic [XLEN-1:0]  pred_target_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             upd_valid_i,
    input  logic [XLEN-1:0]  upd_pc_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic [XLEN-1:0]  upd_target_i,
    input  logic             upd_pred_taken_i,
    input  logic [XLEN-1:0]  upd_pred_target_i,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] stat_lookups_o,
    output logic [CNT_W-1:0] stat_branches_o,
    output logic [CNT_W-1:0] stat_mispred_o
);

    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [1:0]       bht_q [ENTRIES];
    logic [ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0] btb_tag_q [ENTRIES];
    logic [XLEN-1:0]  btb_target_q [ENTRIES];
    logic [GHR_W-1:0] ghr_q;
    logic [1:0]       bht_d;
    logic [CNT_W-1:0] lookups_q, branches_q, mispred_q;
    logic [CNT_W-1:0] lookups_d, branches_d, mispred_d;
    logic [IDX_W-1:0] lk_bidx, upd_bidx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             hit;

    assign lk_bidx  = IDX_W'(pc_bidx(64'(lk_pc_i), IDX_W));
    assign lk_tag   = TAG_W'(pc_tag(64'(lk_pc_i), IDX_W));
    assign upd_bidx = IDX_W'(pc_bidx(64'(upd_pc_i), IDX_W));
    assign upd_tag  = TAG_W'(pc_tag(64'(upd_pc_i), IDX_W));

    // Lookup reads only registered state, so an update in the same cycle is seen next cycle
    always_comb begin
        hit           = btb_valid_q[lk_bidx] && btb_tag_q[lk_bidx] == lk_tag;
        pred_idx_o    = GSHARE != 0 ? lk_bidx ^ IDX_W'(ghr_q) : lk_bidx;
        pred_taken_o  = rst_i && hit && bht_q[pred_idx_o][1];
        pred_target_o = pred_taken_o ? btb_target_q[lk_bidx] : '0;
    end

    // Redirect when direction differs, or both taken but to different targets
    always_comb begin
        mispredict_o  = rst_i && upd_valid_i &&
                        (upd_taken_i != upd_pred_taken_i ||
                         (upd_taken_i && upd_pred_taken_i && upd_target_i != upd_pred_target_i));
        redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);
    end

    sat_counter #(.W(2)) u_bht_cnt (
        .cnt_i (bht_q[upd_idx_i]),
        .inc_i (upd_taken_i),
        .dec_i (!upd_taken_i),
        .clr_i (1'b0),
        .cnt_o (bht_d)
    );

    sat_counter #(.W(CNT_W)) u_lookups_cnt (
        .cnt_i (lookups_q),
        .inc_i (lk_valid_i),
        .dec_i (1'b0),
        .clr_i (!rst_i),
        .cnt_o (lookups_d)
    );

    sat_counter #(.W(CNT_W)) u_branches_cnt (
        .cnt_i (branches_q),
        .inc_i (upd_valid_i),
        .dec_i (1'b0),
        .clr_i (!rst_i),
        .cnt_o (branches_d)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .cnt_i (mispred_q),
        .inc_i (mispredict_o),
        .dec_i (1'b0),
        .clr_i (!rst_i),
        .cnt_o (mispred_d)
    );

    // Direction counters, BTB valid bits and history; reset discards a concurrent update
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= BHT_RESET;
            btb_valid_q <= '0;
            ghr_q       <= '0;
        end else if (upd_valid_i) begin
            bht_q[upd_idx_i] <= bht_d;
            if (upd_taken_i) btb_valid_q[upd_bidx] <= 1'b1;
            if (GSHARE != 0) ghr_q <= GHR_W'({ghr_q, upd_taken_i});
        end
    end

    // BTB payload is gated by the valid bits, so it is left unreset
    always_ff @(posedge clk_i) begin
        if (rst_i && upd_valid_i && upd_taken_i) begin
            btb_tag_q[upd_bidx]    <= upd_tag;
            btb_target_q[upd_bidx] <= upd_target_i;
        end
    end

    // Statistics clear through their counters while reset is held
    always_ff @(posedge clk_i) begin
        lookups_q  <= lookups_d;
        branches_q <= branches_d;
        mispred_q  <= mispred_d;
    end

    assign stat_lookups_o  = lookups_q;
    assign stat_branches_o = branches_q;
    assign stat_mispred_o  = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, update, aliasing, saturation, gshare and reset
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst, lk_valid, upd_valid, upd_taken, upd_ptaken;
    logic [31:0] lk_pc, upd_pc, upd_target, upd_ptarget;
    logic [3:0]  upd_idx;
    logic        pred_taken, misp, g_pred_taken, g_misp;
    logic [31:0] pred_target, redirect, g_pred_target, g_redirect;
    logic [3:0]  pred_idx, g_pred_idx;
    logic [31:0] st_lk, st_br, st_mp, g_st_lk, g_st_br, g_st_mp;
    int checks = 0, failures = 0;
    int exp_lk = 0, exp_br = 0, exp_mp = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk_i(clk), .rst_i(rst), .lk_valid_i(lk_valid), .lk_pc_i(lk_pc),
        .pred_taken_o(pred_taken), .pred_target_o(pred_target), .pred_idx_o(pred_idx),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_pred_taken_i(upd_ptaken), .upd_pred_target_i(upd_ptarget),
        .mispredict_o(misp), .redirect_pc_o(redirect),
        .stat_lookups_o(st_lk), .stat_branches_o(st_br), .stat_mispred_o(st_mp)
    );

    branch_predictor #(.GSHARE(1)) dut_g (
        .clk_i(clk), .rst_i(rst), .lk_valid_i(lk_valid), .lk_pc_i(lk_pc),
        .pred_taken_o(g_pred_taken), .pred_target_o(g_pred_target), .pred_idx_o(g_pred_idx),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_pred_taken_i(upd_ptaken), .upd_pred_target_i(upd_ptarget),
        .mispredict_o(g_misp), .redirect_pc_o(g_redirect),
        .stat_lookups_o(g_st_lk), .stat_branches_o(g_st_br), .stat_mispred_o(g_st_mp)
    );

    // Advance one cycle, tracking expected statistics from the inputs presented at the edge
    task automatic step();
        if (!rst) begin
            exp_lk = 0; exp_br = 0; exp_mp = 0;
        end else begin
            if (lk_valid) exp_lk++;
            if (upd_valid) exp_br++;
            if (upd_valid && (upd_taken != upd_ptaken || (upd_taken && upd_target != upd_ptarget))) exp_mp++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                           input logic pt, input logic [31:0] ptg);
        upd_valid = 1'b1; upd_pc = pc; upd_idx = pc[5:2];
        upd_taken = t; upd_target = tg; upd_ptaken = pt; upd_ptarget = ptg;
    endtask

    task automatic reset_dut();
        rst = 1'b0; lk_valid = 1'b0; upd_valid = 1'b0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        lk_pc = 32'h0; upd_pc = 32'h0; upd_idx = 4'h0; upd_taken = 1'b0;
        upd_target = 32'h0; upd_ptaken = 1'b0; upd_ptarget = 32'h0;
        reset_dut();
        lk_pc = 32'h40; #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%0h exp=0", pred_taken); end
        checks++; if (pred_idx !== 4'h0) begin failures++; $display("FAIL reset_pred_idx got=%0h exp=0", pred_idx); end
        checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL reset_pred_target got=%0h exp=0", pred_target); end
        checks++; if (misp !== 1'b0) begin failures++; $display("FAIL reset_mispredict got=%0h exp=0", misp); end
        checks++; if (st_lk !== 32'd0 || st_br !== 32'd0 || st_mp !== 32'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", st_lk, st_br, st_mp); end
    endtask

    task automatic test_train();
        set_upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0); #1;
        checks++; if (misp !== 1'b1 || redirect !== 32'h80) begin failures++; $display("FAIL train1_redirect got=%0h/%0h exp=1/80", misp, redirect); end
        step();
        set_upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0); #1;
        checks++; if (misp !== 1'b1 || redirect !== 32'h80) begin failures++; $display("FAIL train2_redirect got=%0h/%0h exp=1/80", misp, redirect); end
        step();
        upd_valid = 1'b0; lk_valid = 1'b1; lk_pc = 32'h40; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin failures++; $display("FAIL train_lookup got=%0h/%0h exp=1/80", pred_taken, pred_target); end
        checks++; if (st_mp !== 32'd2 || st_br !== 32'd2) begin failures++; $display("FAIL train_stats got=%0d/%0d exp=2/2", st_mp, st_br); end
        step();
    endtask

    task automatic test_alias();
        lk_pc = 32'h80; #1;
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0 || pred_idx !== 4'h0) begin failures++; $display("FAIL alias_miss got=%0h/%0h/%0h exp=0/0/0", pred_taken, pred_target, pred_idx); end
        set_upd(32'h80, 1'b1, 32'h100, 1'b0, 32'h0); #1;
        checks++; if (misp !== 1'b1 || redirect !== 32'h100) begin failures++; $display("FAIL alias_redirect got=%0h/%0h exp=1/100", misp, redirect); end
        step();
        upd_valid = 1'b0; lk_pc = 32'h40; #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_old_evicted got=%0h exp=0", pred_taken); end
        lk_pc = 32'h80; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin failures++; $display("FAIL alias_new_hit got=%0h/%0h exp=1/100", pred_taken, pred_target); end
        checks++; if (st_lk !== exp_lk || st_lk !== 32'd2) begin failures++; $display("FAIL alias_lookups got=%0d exp=2", st_lk); end
        step();
        lk_valid = 1'b0;
    endtask

    task automatic test_mispredict_cases();
        set_upd(32'h80, 1'b1, 32'h100, 1'b1, 32'h104); #1;
        checks++; if (misp !== 1'b1 || redirect !== 32'h100) begin failures++; $display("FAIL target_mismatch got=%0h/%0h exp=1/100", misp, redirect); end
        set_upd(32'h80, 1'b1, 32'h100, 1'b1, 32'h100); #1;
        checks++; if (misp !== 1'b0) begin failures++; $display("FAIL correct_taken got=%0h exp=0", misp); end
        set_upd(32'h80, 1'b0, 32'h100, 1'b0, 32'h999); #1;
        checks++; if (misp !== 1'b0 || redirect !== 32'h84) begin failures++; $display("FAIL correct_not_taken got=%0h/%0h exp=0/84", misp, redirect); end
        set_upd(32'h80, 1'b1, 32'h100, 1'b0, 32'h0); upd_valid = 1'b0; #1;
        checks++; if (misp !== 1'b0) begin failures++; $display("FAIL invalid_gated got=%0h exp=0", misp); end
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            set_upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
            step();
        end
        lk_valid = 1'b1; lk_pc = 32'h40;
        set_upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80); #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_pred_strong got=%0h exp=1", pred_taken); end
        checks++; if (misp !== 1'b1 || redirect !== 32'h44) begin failures++; $display("FAIL sat_not_taken_redirect got=%0h/%0h exp=1/44", misp, redirect); end
        step();
        upd_valid = 1'b0; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin failures++; $display("FAIL sat_weak_taken got=%0h/%0h exp=1/80", pred_taken, pred_target); end
        set_upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
        step();
        upd_valid = 1'b0; #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_weak_not_taken got=%0h exp=0", pred_taken); end
        checks++; if (st_br !== 32'd7 || st_mp !== 32'd2 || st_mp !== exp_mp) begin failures++; $display("FAIL sat_stats got=%0d/%0d exp=7/2", st_br, st_mp); end
    endtask

    task automatic test_same_cycle();
        lk_valid = 1'b1; lk_pc = 32'h40;
        set_upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0); #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL same_cycle_old got=%0h exp=0", pred_taken); end
        step();
        upd_valid = 1'b0; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin failures++; $display("FAIL same_cycle_new got=%0h/%0h exp=1/80", pred_taken, pred_target); end
        lk_valid = 1'b0;
    endtask

    task automatic test_gshare();
        reset_dut();
        set_upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);  step();
        set_upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80); step();
        set_upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80); step();
        upd_valid = 1'b0; lk_pc = 32'h40; #1;
        checks++; if (g_pred_idx !== 4'h6) begin failures++; $display("FAIL gshare_idx got=%0h exp=6", g_pred_idx); end
        checks++; if (pred_idx !== 4'h0) begin failures++; $display("FAIL bimodal_idx got=%0h exp=0", pred_idx); end
        checks++; if (g_pred_taken !== 1'b0) begin failures++; $display("FAIL gshare_taken got=%0h exp=0", g_pred_taken); end
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL bimodal_taken got=%0h exp=1", pred_taken); end
    endtask

    task automatic test_reset_mid();
        lk_valid = 1'b1; lk_pc = 32'h40; rst = 1'b0;
        set_upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h0); #1;
        checks++; if (misp !== 1'b0) begin failures++; $display("FAIL rstmid_misp got=%0h exp=0", misp); end
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin failures++; $display("FAIL rstmid_pred got=%0h/%0h exp=0/0", pred_taken, pred_target); end
        step();
        rst = 1'b1; upd_valid = 1'b0; lk_valid = 1'b0; #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rstmid_cleared_40 got=%0h exp=0", pred_taken); end
        lk_pc = 32'h80; #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rstmid_discarded_80 got=%0h exp=0", pred_taken); end
        checks++; if (st_lk !== 32'd0 || st_br !== 32'd0 || st_mp !== 32'd0 || g_st_br !== 32'd0) begin failures++; $display("FAIL rstmid_stats got=%0d/%0d/%0d exp=0/0/0", st_lk, st_br, st_mp); end
    endtask

    initial begin
        rst = 1'b0; lk_valid = 1'b0; upd_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_train();
        test_alias();
        test_mispredict_cases();
        test_saturation();
        test_same_cycle();
        test_gshare();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch prediction unit for the 5-stage pipelined CPU.
- Replaces the fixed "predict not-taken, flush IF on taken beq resolved in ID" scheme.
- IF stage does a same-cycle lookup on the fetch PC and gets a predicted direction and target.
- ID stage reports each resolved branch. The block updates a 2-bit counter table (BHT) and a tagged target buffer (BTB), raises mispredict/redirect for the PC mux and IF_ID flush, and keeps saturating performance counters.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, number of BTB and BHT entries; power of two, ≥4. IDX_W = log2(ENTRIES).
- GSHARE, 0. 0 = bimodal index; 1 = index XOR global history.
- GHR_W, 4, global history register width; must be ≤ IDX_W.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i, in, 1, clock; all state changes on rising edge.
- rst_i, in, 1, synchronous active-low reset.
- lk_valid_i, in, 1, IF advancing this cycle (PCWrite); gates lookup statistics only.
- lk_pc_i, in, XLEN, fetch PC.
- pred_taken_o, out, 1, predicted taken.
- pred_target_o, out, XLEN, predicted target; 0 when not taken.
- pred_idx_o, out, IDX_W, BHT index used; carried through IF_ID and returned on update.
- upd_valid_i, in, 1, branch resolved in ID this cycle.
- upd_pc_i, in, XLEN, PC of resolved branch.
- upd_idx_i, in, IDX_W, pred_idx carried with the branch.
- upd_taken_i, in, 1, actual direction.
- upd_target_i, in, XLEN, actual taken target.
- upd_pred_taken_i, in, 1, prediction carried with the branch.
- upd_pred_target_i, in, XLEN, predicted target carried with the branch.
- mispredict_o, out, 1, redirect required; drives PC mux select and IF_Flush.
- redirect_pc_o, out, XLEN, correct next PC.
- stat_lookups_o, out, CNT_W, count of lookups.
- stat_branches_o, out, CNT_W, count of resolved branches.
- stat_mispred_o, out, CNT_W, count of mispredicts.

Behaviour:
- Indexing:
  - bidx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
  - hidx = bidx if GSHARE=0, else bidx XOR zero-extended GHR.
- Lookup (combinational, 0 latency, reads registered state):
  - hit = btb_valid[bidx] && btb_tag[bidx]==tag.
  - pred_taken_o = hit && bht[hidx][1].
  - pred_target_o = pred_taken_o ? btb_target[bidx] : 0.
  - pred_idx_o = hidx.
  - While rst_i==0: pred_taken_o=0, pred_target_o=0.
- Mispredict (combinational on update inputs, gated by upd_valid_i):
  - Asserted when upd_taken_i != upd_pred_taken_i, or when both are 1 and upd_target_i != upd_pred_target_i.
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4. Value is don't-care-free: always driven.
  - mispredict_o=0 when upd_valid_i=0 or during reset.
- Update (registered, on clock edge with upd_valid_i=1):
  - bht[upd_idx_i]: saturating increment if taken, decrement if not. Range 00..11; no wrap.
  - If taken: write btb_valid=1, tag and target at upd_pc_i's bidx; overwrites any alias.
  - If not taken: BTB unchanged.
  - If GSHARE=1: GHR <= {GHR[GHR_W-2:0], upd_taken_i}. GHR is updated non-speculatively, only here.
- Simultaneous lookup and update to the same entry: lookup returns the pre-update value; the new value is visible the next cycle.
- Statistics:
  - stat_lookups increments on lk_valid_i.
  - stat_branches increments on upd_valid_i.
  - stat_mispred increments on mispredict_o.
  - All saturate at all-ones; no wrap.
- Reset (rst_i==0 at an edge): all btb_valid=0, all bht=2'b01 (weakly not-taken), GHR=0, all stats=0. Reset mid-update discards the update.
- No internal FSM beyond the tables. Every table write completes in one cycle; no stall output.

Decomposition:
- Shared package holds:
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
  - BHT_RESET=WNT.
  - Index/tag slice helper functions parametrised on IDX_W.
- One natural sub-module: sat_counter (parametrised width, inc/dec/clear, saturating). Used for the 2-bit BHT update logic and the three statistic counters.

Test Plan:
- Reset then lookup 0x40: pred_taken_o=0, pred_idx_o=0x0, all stats 0, mispredict_o=0.
- Branch at 0x40 resolved taken to 0x80, twice (pred_taken=0):
  - Both updates: mispredict_o=1, redirect_pc_o=0x80.
  - After the second update: lookup 0x40 gives pred_taken_o=1, pred_target_o=0x80.
  - stat_mispred=2.
- Aliasing, ENTRIES=16: train 0x40 taken, then lookup 0x80 (same bidx, different tag) -> pred_taken_o=0.
  - Then resolve 0x80 taken to 0x100 -> BTB entry replaced; lookup 0x40 now misses.
- Saturation: five taken updates, then one not-taken on idx 0 -> counter 11 then 10; still predicts taken, mispredict_o=1 on the not-taken, redirect_pc_o=0x44.
- GSHARE=1: updates taken, taken, not-taken -> GHR=4'b0110; lookup 0x40 gives pred_idx_o=0x0^0x6=0x6.
- Same-cycle update and lookup of 0x40: pre-update prediction returned that cycle, new prediction next cycle. rst_i=0 asserted mid-stream clears everything at the next edge.
